// File: rtl/tpx3_tcp_tx_serializer_pkg.sv
// Shared types and helpers for the TPX3 TCP transmit serializer.
// FSM state encoding, counter widths and the byte-lane selector.
package tpx3_tcp_tx_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_FLUSH = 2'd2
  } tx_state_t;

  localparam int WORD_W = 32;
  localparam int DROP_W = 16;

  // Lane 0 is the first byte on the wire; lsb_first picks which end of the word that is.
  function automatic logic [7:0] byte_lane(input logic [31:0] word,
                                           input logic [1:0]  bidx,
                                           input logic        lsb_first);
    logic [1:0] lane;
    logic [7:0] sel;
    lane = lsb_first ? bidx : ~bidx;
    case (lane)
      2'd0:    sel = word[7:0];
      2'd1:    sel = word[15:8];
      2'd2:    sel = word[23:16];
      default: sel = word[31:24];
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/tcp_word_fifo.sv
// Show-ahead synchronous word FIFO; head word is valid whenever EMPTY is low.
// Writes while FULL are ignored even if a read happens in the same cycle.
module tcp_word_fifo #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  BUS_CLK,
  input  logic                  BUS_RST_N,
  input  logic                  WR,
  input  logic [31:0]           DIN,
  input  logic                  RD,
  output logic [31:0]           DOUT,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic [DEPTH_LOG2:0]   OCC
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   OCC_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   OCC_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   occ;
  logic                  push;
  logic                  pop;

  assign EMPTY = (occ == '0);
  assign FULL  = (occ == OCC_FULL);
  assign OCC   = occ;
  assign DOUT  = mem[rd_ptr];
  assign push  = WR && !FULL;
  assign pop   = RD && !EMPTY;

  // Storage is deliberately not reset; contents are meaningless once occ is cleared.
  always_ff @(posedge BUS_CLK) begin
    if (push) mem[wr_ptr] <= DIN;
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/tpx3_tcp_tx_serializer.sv
// TPX3 readout tail: buffers arbiter words and serializes them into bytes for SiTCP TX.
// Data is discarded (and counted) whenever the TCP connection is closed.
//
// state | meaning
// IDLE  | waiting for a queued word with the connection open
// SEND  | emitting the 4 bytes of WORD_REG, stalling on TCP_TX_FULL
// FLUSH | connection closed: popping and counting every queued word
module tpx3_tcp_tx_serializer
  import tpx3_tcp_tx_serializer_pkg::*;
#(
  parameter int DEPTH_LOG2   = 10,
  parameter int READY_MARGIN = 4,
  parameter int LSB_FIRST    = 1
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST_N,
  input  logic        ARB_WRITE_OUT,
  input  logic [31:0] ARB_DATA_OUT,
  output logic        ARB_READY_OUT,
  input  logic        TCP_OPEN_ACK,
  input  logic        TCP_TX_FULL,
  output logic        TCP_TX_WR,
  output logic [7:0]  TCP_TX_DATA,
  output logic        FIFO_EMPTY,
  output logic [31:0] WORD_COUNT,
  output logic [15:0] DROP_COUNT
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] OCC_ONE     = 1;
  localparam logic [DEPTH_LOG2:0] READY_LIMIT = (DEPTH_LOG2+1)'(DEPTH - READY_MARGIN);
  localparam logic                LSB_SEL     = (LSB_FIRST != 0);

  logic [31:0]         fifo_dout;
  logic                fifo_empty;
  logic                fifo_full;
  logic [DEPTH_LOG2:0] occ;
  logic [DEPTH_LOG2:0] occ_next;
  logic                fifo_rd;
  logic                push_ok;
  logic                ovf_drop;

  tx_state_t   state;
  tx_state_t   state_next;
  logic [31:0] word_reg;
  logic [31:0] word_next;
  logic [1:0]  bidx;
  logic [1:0]  bidx_next;
  logic        wr_next;
  logic [7:0]  data_next;
  logic        word_done;
  logic        fsm_drop;

  logic [1:0]        drop_inc;
  logic [DROP_W:0]   drop_sum;

  tcp_word_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .BUS_CLK   (BUS_CLK),
    .BUS_RST_N (BUS_RST_N),
    .WR        (ARB_WRITE_OUT),
    .DIN       (ARB_DATA_OUT),
    .RD        (fifo_rd),
    .DOUT      (fifo_dout),
    .EMPTY     (fifo_empty),
    .FULL      (fifo_full),
    .OCC       (occ)
  );

  assign FIFO_EMPTY = fifo_empty;
  assign push_ok    = ARB_WRITE_OUT && !fifo_full;
  assign ovf_drop   = ARB_WRITE_OUT && fifo_full;

  always_comb begin
    occ_next = occ;
    if (push_ok && !fifo_rd)      occ_next = occ + OCC_ONE;
    else if (!push_ok && fifo_rd) occ_next = occ - OCC_ONE;
  end

  always_comb begin
    state_next = state;
    word_next  = word_reg;
    bidx_next  = bidx;
    wr_next    = 1'b0;
    data_next  = TCP_TX_DATA;
    fifo_rd    = 1'b0;
    word_done  = 1'b0;
    fsm_drop   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!TCP_OPEN_ACK) begin
          state_next = ST_FLUSH;
        end else if (!fifo_empty) begin
          word_next  = fifo_dout;
          fifo_rd    = 1'b1;
          bidx_next  = 2'd0;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        // A closed connection takes priority over back-pressure.
        if (!TCP_OPEN_ACK) begin
          fsm_drop   = 1'b1;
          state_next = ST_FLUSH;
        end else if (!TCP_TX_FULL) begin
          wr_next   = 1'b1;
          data_next = byte_lane(word_reg, bidx, LSB_SEL);
          bidx_next = bidx + 2'd1;
          if (bidx == 2'd3) begin
            word_done = 1'b1;
            if (!fifo_empty) begin
              word_next = fifo_dout;
              fifo_rd   = 1'b1;
              bidx_next = 2'd0;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
      end
      ST_FLUSH: begin
        // Reopening wins over popping so a word arriving with the link up is sent, not dropped.
        if (TCP_OPEN_ACK) begin
          state_next = ST_IDLE;
        end else if (!fifo_empty) begin
          fifo_rd  = 1'b1;
          fsm_drop = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign drop_inc = {1'b0, ovf_drop} + {1'b0, fsm_drop};
  assign drop_sum = {1'b0, DROP_COUNT} + (DROP_W+1)'(drop_inc);

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state         <= ST_IDLE;
      word_reg      <= '0;
      bidx          <= '0;
      TCP_TX_WR     <= 1'b0;
      TCP_TX_DATA   <= '0;
      ARB_READY_OUT <= 1'b0;
      WORD_COUNT    <= '0;
      DROP_COUNT    <= '0;
    end else begin
      state         <= state_next;
      word_reg      <= word_next;
      bidx          <= bidx_next;
      TCP_TX_WR     <= wr_next;
      TCP_TX_DATA   <= data_next;
      ARB_READY_OUT <= (occ_next < READY_LIMIT);
      if (word_done) WORD_COUNT <= WORD_COUNT + 32'd1;
      DROP_COUNT    <= drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    end
  end

endmodule

// File: tb/tb_tpx3_tcp_tx_serializer.sv
// Bench for tpx3_tcp_tx_serializer: directed vector table, corner sequences, random stream.
// Random phase predicts the byte stream from the accepted words in order.
module tb_tpx3_tcp_tx_serializer;

  logic        BUS_CLK;
  logic        BUS_RST_N;
  logic        ARB_WRITE_OUT;
  logic [31:0] ARB_DATA_OUT;
  logic        ARB_READY_OUT;
  logic        TCP_OPEN_ACK;
  logic        TCP_TX_FULL;
  logic        TCP_TX_WR;
  logic [7:0]  TCP_TX_DATA;
  logic        FIFO_EMPTY;
  logic [31:0] WORD_COUNT;
  logic [15:0] DROP_COUNT;

  tpx3_tcp_tx_serializer #(
    .DEPTH_LOG2   (4),
    .READY_MARGIN (4),
    .LSB_FIRST    (1)
  ) dut (
    .BUS_CLK       (BUS_CLK),
    .BUS_RST_N     (BUS_RST_N),
    .ARB_WRITE_OUT (ARB_WRITE_OUT),
    .ARB_DATA_OUT  (ARB_DATA_OUT),
    .ARB_READY_OUT (ARB_READY_OUT),
    .TCP_OPEN_ACK  (TCP_OPEN_ACK),
    .TCP_TX_FULL   (TCP_TX_FULL),
    .TCP_TX_WR     (TCP_TX_WR),
    .TCP_TX_DATA   (TCP_TX_DATA),
    .FIFO_EMPTY    (FIFO_EMPTY),
    .WORD_COUNT    (WORD_COUNT),
    .DROP_COUNT    (DROP_COUNT)
  );

  initial BUS_CLK = 1'b0;
  always #5 BUS_CLK = ~BUS_CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] got[$];
  int         got_cyc[$];
  logic       prev_full = 1'b0;

  typedef struct {
    logic [31:0]      data;
    int               stall_at;
    int               stall_len;
    logic [3:0][7:0]  exp;
  } vec_t;

  vec_t vec [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge BUS_CLK);
    #1;
  endtask

  always @(posedge BUS_CLK) cyc <= cyc + 1;

  // Byte capture plus the link rule: a written byte must come from an edge that saw FULL low.
  always @(negedge BUS_CLK) begin
    if (BUS_RST_N && TCP_TX_WR) begin
      got.push_back(TCP_TX_DATA);
      got_cyc.push_back(cyc);
      check("wr_while_full", 32'(prev_full), 32'd0);
    end
    prev_full = TCP_TX_FULL;
  end

  task automatic do_reset();
    BUS_RST_N = 1'b0;
    ARB_WRITE_OUT = 1'b0;
    #1;
    check("rst_word_count", WORD_COUNT, 32'd0);
    check("rst_drop_count", 32'(DROP_COUNT), 32'd0);
    tick();
    tick();
    BUS_RST_N = 1'b1;
    tick();
    got.delete();
    got_cyc.delete();
  endtask

  initial begin
    logic [31:0] w8 [8];
    logic [31:0] w20 [20];
    logic [31:0] exp_q[$];
    int          wcyc;
    int          nwords;
    int          acc;
    int          infifo;

    BUS_RST_N     = 1'b0;
    ARB_WRITE_OUT = 1'b0;
    ARB_DATA_OUT  = '0;
    TCP_OPEN_ACK  = 1'b0;
    TCP_TX_FULL   = 1'b0;

    // Reset held 5 cycles, READY one edge after release.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_ready", 32'(ARB_READY_OUT), 32'd0);
      check("rst_wr", 32'(TCP_TX_WR), 32'd0);
      check("rst_data", 32'(TCP_TX_DATA), 32'd0);
      check("rst_empty", 32'(FIFO_EMPTY), 32'd1);
    end
    BUS_RST_N = 1'b1;
    check("ready_before_edge", 32'(ARB_READY_OUT), 32'd0);
    tick();
    check("ready_after_release", 32'(ARB_READY_OUT), 32'd1);

    TCP_OPEN_ACK = 1'b1;
    tick();
    tick();
    got.delete();
    got_cyc.delete();

    vec[0] = '{32'h11223344, 4, 0, {8'h11, 8'h22, 8'h33, 8'h44}};
    vec[1] = '{32'hAABBCCDD, 2, 3, {8'hAA, 8'hBB, 8'hCC, 8'hDD}};
    vec[2] = '{32'h01020304, 0, 2, {8'h01, 8'h02, 8'h03, 8'h04}};
    vec[3] = '{32'hDEADBEEF, 3, 1, {8'hDE, 8'hAD, 8'hBE, 8'hEF}};

    for (int i = 0; i < 4; i++) begin
      ARB_WRITE_OUT = 1'b1;
      ARB_DATA_OUT  = vec[i].data;
      tick();
      ARB_WRITE_OUT = 1'b0;
      tick();
      for (int b = 0; b < 4; b++) begin
        if (b == vec[i].stall_at) begin
          TCP_TX_FULL = 1'b1;
          for (int s = 0; s < vec[i].stall_len; s++) begin
            tick();
            check("stall_wr", 32'(TCP_TX_WR), 32'd0);
          end
          TCP_TX_FULL = 1'b0;
        end
        tick();
        check($sformatf("vec%0d_wr%0d", i, b), 32'(TCP_TX_WR), 32'd1);
        check($sformatf("vec%0d_byte%0d", i, b), 32'(TCP_TX_DATA), 32'(vec[i].exp[b]));
      end
      tick();
      check("vec_wr_idle", 32'(TCP_TX_WR), 32'd0);
      check("vec_word_count", WORD_COUNT, 32'(i + 1));
      check("vec_empty", 32'(FIFO_EMPTY), 32'd1);
    end

    // 8 back-to-back words: 32 contiguous byte cycles, first one 2 edges after the write.
    got.delete();
    got_cyc.delete();
    for (int i = 0; i < 8; i++) w8[i] = $urandom;
    for (int i = 0; i < 8; i++) begin
      ARB_WRITE_OUT = 1'b1;
      ARB_DATA_OUT  = w8[i];
      tick();
      if (i == 0) wcyc = cyc;
    end
    ARB_WRITE_OUT = 1'b0;
    for (int t = 0; t < 40; t++) tick();
    check("b2b_bytes", 32'(got.size()), 32'd32);
    if (got.size() == 32) begin
      check("b2b_latency", 32'(got_cyc[0]), 32'(wcyc + 2));
      check("b2b_contig", 32'(got_cyc[31] - got_cyc[0]), 32'd31);
      for (int i = 0; i < 32; i++)
        check($sformatf("b2b_byte%0d", i), 32'(got[i]), 32'((w8[i/4] >> (8 * (i % 4))) & 32'hFF));
    end
    check("b2b_word_count", WORD_COUNT, 32'd12);
    check("b2b_empty", 32'(FIFO_EMPTY), 32'd1);

    // Overflow: FULL held, 20 forced writes into a 16-deep FIFO.
    do_reset();
    TCP_TX_FULL = 1'b1;
    for (int i = 0; i < 20; i++) w20[i] = 32'hC0DE0000 + 32'(i * 32'h01010101);
    for (int n = 1; n <= 20; n++) begin
      ARB_WRITE_OUT = 1'b1;
      ARB_DATA_OUT  = w20[n-1];
      tick();
      acc    = (n < 17) ? n : 17;
      infifo = acc - ((n >= 2) ? 1 : 0);
      check($sformatf("ovf_ready%0d", n), 32'(ARB_READY_OUT), 32'(infifo < 12));
    end
    ARB_WRITE_OUT = 1'b0;
    check("ovf_drop", 32'(DROP_COUNT), 32'd3);
    check("ovf_not_empty", 32'(FIFO_EMPTY), 32'd0);
    check("ovf_no_wr", 32'(got.size()), 32'd0);
    TCP_TX_FULL = 1'b0;
    for (int t = 0; t < 120 && got.size() < 68; t++) tick();
    tick();
    check("ovf_drain_bytes", 32'(got.size()), 32'd68);
    if (got.size() == 68)
      for (int i = 0; i < 68; i++)
        check($sformatf("ovf_byte%0d", i), 32'(got[i]), 32'((w20[i/4] >> (8 * (i % 4))) & 32'hFF));
    check("ovf_word_count", WORD_COUNT, 32'd17);
    check("ovf_ready_back", 32'(ARB_READY_OUT), 32'd1);

    // Connection drops after 2 bytes with 5 words queued.
    do_reset();
    TCP_TX_FULL = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ARB_WRITE_OUT = 1'b1;
      ARB_DATA_OUT  = 32'h5A5A0000 + 32'(i);
      tick();
    end
    ARB_WRITE_OUT = 1'b0;
    TCP_TX_FULL = 1'b0;
    tick();
    tick();
    TCP_OPEN_ACK = 1'b0;
    tick();
    check("close_wr_stop", 32'(TCP_TX_WR), 32'd0);
    check("close_drop_partial", 32'(DROP_COUNT), 32'd1);
    for (int t = 0; t < 8; t++) tick();
    check("close_empty", 32'(FIFO_EMPTY), 32'd1);
    check("close_drop_total", 32'(DROP_COUNT), 32'd6);
    check("close_bytes", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      check("close_byte0", 32'(got[0]), 32'h00);
      check("close_byte1", 32'(got[1]), 32'h00);
    end
    check("close_word_count", WORD_COUNT, 32'd0);
    TCP_OPEN_ACK = 1'b1;
    tick();
    ARB_WRITE_OUT = 1'b1;
    ARB_DATA_OUT  = 32'h01020304;
    tick();
    ARB_WRITE_OUT = 1'b0;
    for (int t = 0; t < 10; t++) tick();
    check("reopen_bytes", 32'(got.size()), 32'd6);
    if (got.size() == 6) begin
      check("reopen_b0", 32'(got[2]), 32'h04);
      check("reopen_b1", 32'(got[3]), 32'h03);
      check("reopen_b2", 32'(got[4]), 32'h02);
      check("reopen_b3", 32'(got[5]), 32'h01);
    end
    check("reopen_word_count", WORD_COUNT, 32'd1);
    check("reopen_drop", 32'(DROP_COUNT), 32'd6);

    // Random stream honouring READY with random back-pressure.
    do_reset();
    nwords = 0;
    for (int t = 0; t < 600; t++) begin
      TCP_TX_FULL = ($urandom_range(0, 3) == 0);
      if (ARB_READY_OUT && ($urandom_range(0, 1) == 1)) begin
        ARB_WRITE_OUT = 1'b1;
        ARB_DATA_OUT  = $urandom;
        for (int b = 0; b < 4; b++) exp_q.push_back((ARB_DATA_OUT >> (8 * b)) & 32'hFF);
        nwords++;
      end else begin
        ARB_WRITE_OUT = 1'b0;
      end
      tick();
    end
    ARB_WRITE_OUT = 1'b0;
    TCP_TX_FULL   = 1'b0;
    for (int t = 0; t < 2000 && got.size() < exp_q.size(); t++) tick();
    for (int t = 0; t < 5; t++) tick();
    check("rand_byte_total", 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("rand_byte%0d", i), 32'(got[i]), exp_q[i]);
    check("rand_word_count", WORD_COUNT, 32'(nwords));
    check("rand_drop", 32'(DROP_COUNT), 32'd0);
    check("rand_empty", 32'(FIFO_EMPTY), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
